score_counter: RTL and testbench

SCORE_COUNTER -- requirements
Module: score_counter

---
 rtl/score_pkg.sv | 44 ++++
 rtl/bcd_digit_add.sv | 24 ++
 rtl/score_counter.sv | 175 +++++++++++++++++
 tb/tb_score_counter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared types and constants for the score counter: FSM states, BCD addends
// and the geometry of the on-screen digit fields.
package score_pkg;

  localparam int unsigned NumDigits = 5;
  localparam int unsigned DigitPx   = 16;
  localparam int unsigned FieldW    = NumDigits * DigitPx;

  // Five packed BCD digits, digit 0 is the least significant.
  typedef logic [NumDigits-1:0][3:0] bcd_t;

  typedef enum logic [1:0] {
    StIdle,
    StAdd,
    StCommit,
    StCmp
  } state_e;

  // Bit positions inside the pending-event vector.
  localparam int unsigned PendPellet = 0;
  localparam int unsigned PendPower  = 1;
  localparam int unsigned PendGhost  = 2;

  localparam bcd_t AddPellet = 20'h00010;
  localparam bcd_t AddPower  = 20'h00050;
  localparam bcd_t AddGhost0 = 20'h00200;
  localparam bcd_t AddGhost1 = 20'h00400;
  localparam bcd_t AddGhost2 = 20'h00800;
  localparam bcd_t AddGhost3 = 20'h01600;
  localparam bcd_t ScoreMax  = 20'h99999;

  // Ghost value doubles along the chain and stays at 1600 once saturated.
  function automatic bcd_t ghost_addend(input logic [1:0] chain);
    bcd_t val;
    case (chain)
      2'd0:    val = AddGhost0;
      2'd1:    val = AddGhost1;
      2'd2:    val = AddGhost2;
      default: val = AddGhost3;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single BCD digit adder: a + b + carry_in -> decimal digit and carry_out.
module bcd_digit_add (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       carry_i,
  output logic [3:0] sum_o,
  output logic       carry_o
);

  logic [4:0] raw;

  // Binary sum then decimal correction when the digit overflows past 9.
  always_comb begin
    raw = {1'b0, a_i} + {1'b0, b_i} + {4'b0, carry_i};
    if (raw > 5'd9) begin
      sum_o   = 4'(raw - 5'd10);
      carry_o = 1'b1;
    end else begin
      sum_o   = raw[3:0];
      carry_o = 1'b0;
    end
  end

endmodule

// File: rtl/score_counter.sv
// Game score keeper: latches scoring events, adds their BCD value one digit
// per cycle through a shared digit adder, tracks the high score and maps both
// 5-digit fields onto the VGA raster for the font renderer.
module score_counter
  import score_pkg::*;
#(
  parameter int unsigned SCORE_X0 = 16,
  parameter int unsigned HIGH_X0  = 480,
  parameter int unsigned ROW_Y0   = 0
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       new_game,
  input  logic       pellet_eaten,
  input  logic       power_eaten,
  input  logic       ghost_eaten,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic [3:0] score_bit,
  output logic       in_score_area,
  output logic       busy,
  output logic       drop_err
);

  state_e     state_q, state_d;
  bcd_t       score_q, score_d;
  bcd_t       high_q, high_d;
  bcd_t       work_q, work_d;
  bcd_t       addend_q, addend_d;
  logic [2:0] idx_q, idx_d;
  logic       carry_q, carry_d;
  logic [2:0] pend_q, pend_d;
  logic [1:0] chain_q, chain_d;
  logic       drop_q, drop_d;

  logic [2:0] ev;
  logic [2:0] pend_clr;
  logic [3:0] dig_sum;
  logic       dig_carry;

  assign ev = {ghost_eaten, power_eaten, pellet_eaten};

  bcd_digit_add u_digit_add (
    .a_i     (work_q[idx_q]),
    .b_i     (addend_q[idx_q]),
    .carry_i (carry_q),
    .sum_o   (dig_sum),
    .carry_o (dig_carry)
  );

  // State register with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= StIdle;
      score_q  <= '0;
      high_q   <= '0;
      work_q   <= '0;
      addend_q <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      pend_q   <= '0;
      chain_q  <= '0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      score_q  <= score_d;
      high_q   <= high_d;
      work_q   <= work_d;
      addend_q <= addend_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      pend_q   <= pend_d;
      chain_q  <= chain_d;
      drop_q   <= drop_d;
    end
  end

  // Event latching, dispatch FSM and digit-serial add.
  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    high_d   = high_q;
    work_d   = work_q;
    addend_d = addend_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    chain_d  = chain_q;
    pend_clr = '0;
    // An event hitting an already-pending flag is lost.
    drop_d   = drop_q | (|(ev & pend_q));

    case (state_q)
      StIdle: begin
        if (|pend_q) begin
          work_d  = score_q;
          idx_d   = '0;
          carry_d = 1'b0;
          state_d = StAdd;
          if (pend_q[PendGhost]) begin
            pend_clr[PendGhost] = 1'b1;
            addend_d = ghost_addend(chain_q);
            if (chain_q != 2'd3) chain_d = chain_q + 2'd1;
          end else if (pend_q[PendPower]) begin
            pend_clr[PendPower] = 1'b1;
            addend_d = AddPower;
          end else begin
            pend_clr[PendPellet] = 1'b1;
            addend_d = AddPellet;
          end
        end
      end
      StAdd: begin
        work_d[idx_q] = dig_sum;
        carry_d       = dig_carry;
        if (idx_q == 3'(NumDigits - 1)) state_d = StCommit;
        else idx_d = idx_q + 3'd1;
      end
      StCommit: begin
        // Carry out of the top digit means the score overflowed: pin it.
        score_d = carry_q ? ScoreMax : work_q;
        state_d = StCmp;
      end
      StCmp: begin
        if (score_q > high_q) high_d = score_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    pend_d = (pend_q & ~pend_clr) | (ev & ~pend_q);

    // A freshly sampled power pellet restarts the chain, even over a dispatch.
    if (power_eaten) chain_d = '0;

    // new_game wins over everything sampled alongside it, but keeps high/drop.
    if (new_game) begin
      state_d = StIdle;
      score_d = '0;
      work_d  = '0;
      idx_d   = '0;
      carry_d = 1'b0;
      pend_d  = '0;
      chain_d = '0;
      drop_d  = drop_q;
    end
  end

  assign busy     = (state_q != StIdle);
  assign drop_err = drop_q;

  logic [31:0] y_off, sx_off, hx_off;
  logic [2:0]  col;
  logic        in_rows;

  // Raster lookup; offsets wrap huge when left of / above a field.
  always_comb begin
    y_off         = 32'(DrawY) - ROW_Y0;
    sx_off        = 32'(DrawX) - SCORE_X0;
    hx_off        = 32'(DrawX) - HIGH_X0;
    in_rows       = (y_off < DigitPx);
    col           = '0;
    score_bit     = '0;
    in_score_area = 1'b0;
    if (in_rows && (sx_off < FieldW)) begin
      col           = 3'(sx_off >> $clog2(DigitPx));
      score_bit     = score_q[3'd4 - col];
      in_score_area = 1'b1;
    end else if (in_rows && (hx_off < FieldW)) begin
      col           = 3'(hx_off >> $clog2(DigitPx));
      score_bit     = high_q[3'd4 - col];
      in_score_area = 1'b1;
    end
  end

endmodule

// File: tb/tb_score_counter.sv
// Directed bench for score_counter: event table, display table and
// hand-written multi-cycle sequences (latency, ordering, drops, saturation).
module tb_score_counter;

  localparam int unsigned SX0 = 16;
  localparam int unsigned HX0 = 480;
  localparam int unsigned RY0 = 0;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       new_game, pellet, power, ghost;
  logic [9:0] DrawX, DrawY;
  logic [3:0] score_bit;
  logic       in_score_area, busy, drop_err;

  int n_checks = 0;
  int n_fail   = 0;

  score_counter #(
    .SCORE_X0 (SX0),
    .HIGH_X0  (HX0),
    .ROW_Y0   (RY0)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .new_game      (new_game),
    .pellet_eaten  (pellet),
    .power_eaten   (power),
    .ghost_eaten   (ghost),
    .DrawX         (DrawX),
    .DrawY         (DrawY),
    .score_bit     (score_bit),
    .in_score_area (in_score_area),
    .busy          (busy),
    .drop_err      (drop_err)
  );

  always #20 Clk = ~Clk;

  typedef struct {
    logic ng;
    logic pel;
    logic pow;
    logic gh;
    int   score;
    int   high;
  } ev_vec_t;

  typedef struct {
    int   x;
    int   y;
    int   bits;
    logic in_area;
  } disp_vec_t;

  ev_vec_t   evs[$];
  disp_vec_t dvs[$];

  function automatic ev_vec_t mk_ev(logic ng, logic pel, logic pow, logic gh, int s, int h);
    ev_vec_t v;
    v.ng = ng; v.pel = pel; v.pow = pow; v.gh = gh; v.score = s; v.high = h;
    return v;
  endfunction

  function automatic disp_vec_t mk_dv(int x, int y, int b, logic in_a);
    disp_vec_t v;
    v.x = x; v.y = y; v.bits = b; v.in_area = in_a;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse(input logic ng, input logic pel, input logic pow, input logic gh);
    new_game = ng; pellet = pel; power = pow; ghost = gh;
    tick();
    new_game = 1'b0; pellet = 1'b0; power = 1'b0; ghost = 1'b0;
  endtask

  // Reads both fields through the raster interface as decimal numbers.
  task automatic read_fields(output int sc, output int hi);
    sc = 0;
    hi = 0;
    DrawY = 10'(RY0 + 3);
    for (int i = 0; i < 5; i++) begin
      DrawX = 10'(SX0 + 16 * i);
      #1;
      sc = sc * 10 + int'(score_bit);
    end
    for (int i = 0; i < 5; i++) begin
      DrawX = 10'(HX0 + 16 * i);
      #1;
      hi = hi * 10 + int'(score_bit);
    end
    DrawX = 10'd0;
    DrawY = 10'd200;
  endtask

  task automatic check_fields(input string name, input int exp_sc, input int exp_hi);
    int sc, hi;
    read_fields(sc, hi);
    check({name, " score"}, sc, exp_sc);
    check({name, " high"}, hi, exp_hi);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int m;
    int ci;
    int gadd[4];
    gadd = '{200, 400, 800, 1600};

    Reset = 1'b1;
    new_game = 1'b0; pellet = 1'b0; power = 1'b0; ghost = 1'b0;
    DrawX = 10'd0; DrawY = 10'd200;
    ticks(3);
    Reset = 1'b0;

    check_fields("reset", 0, 0);
    check("reset busy", int'(busy), 0);
    check("reset drop_err", int'(drop_err), 0);

    // Single pellet: latency and busy window.
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check("lat busy k", int'(busy), 0);
    for (int c = 1; c <= 7; c++) begin
      tick();
      check($sformatf("lat busy k+%0d", c), int'(busy), 1);
      if (c == 6) check_fields("lat k+6", 0, 0);
      if (c == 7) check_fields("lat k+7", 10, 0);
    end
    tick();
    check("lat busy k+8", int'(busy), 0);
    check_fields("lat k+8", 10, 10);

    // Event table: each pulse followed by a full add/commit/compare.
    for (int i = 2; i <= 9; i++) evs.push_back(mk_ev(1'b0, 1'b1, 1'b0, 1'b0, i * 10, i * 10));
    evs.push_back(mk_ev(1'b0, 1'b1, 1'b0, 1'b0, 100, 100));
    evs.push_back(mk_ev(1'b0, 1'b0, 1'b1, 1'b0, 150, 150));
    evs.push_back(mk_ev(1'b0, 1'b0, 1'b0, 1'b1, 350, 350));
    evs.push_back(mk_ev(1'b0, 1'b0, 1'b0, 1'b1, 750, 750));
    evs.push_back(mk_ev(1'b0, 1'b0, 1'b0, 1'b1, 1550, 1550));
    evs.push_back(mk_ev(1'b0, 1'b0, 1'b0, 1'b1, 3150, 3150));
    evs.push_back(mk_ev(1'b0, 1'b0, 1'b0, 1'b1, 4750, 4750));
    evs.push_back(mk_ev(1'b1, 1'b0, 1'b0, 1'b0, 0, 4750));
    evs.push_back(mk_ev(1'b0, 1'b0, 1'b1, 1'b0, 50, 4750));
    evs.push_back(mk_ev(1'b0, 1'b0, 1'b0, 1'b1, 250, 4750));
    evs.push_back(mk_ev(1'b0, 1'b0, 1'b0, 1'b1, 650, 4750));
    evs.push_back(mk_ev(1'b0, 1'b0, 1'b0, 1'b1, 1450, 4750));
    evs.push_back(mk_ev(1'b0, 1'b0, 1'b0, 1'b1, 3050, 4750));
    evs.push_back(mk_ev(1'b0, 1'b0, 1'b0, 1'b1, 4650, 4750));
    foreach (evs[i]) begin
      pulse(evs[i].ng, evs[i].pel, evs[i].pow, evs[i].gh);
      ticks(8);
      check_fields($sformatf("ev[%0d]", i), evs[i].score, evs[i].high);
    end
    check("table drop_err", int'(drop_err), 0);

    // Display table with score 04650 and high 04750.
    dvs.push_back(mk_dv(16, 3, 0, 1'b1));
    dvs.push_back(mk_dv(32, 3, 4, 1'b1));
    dvs.push_back(mk_dv(48, 3, 6, 1'b1));
    dvs.push_back(mk_dv(64, 3, 5, 1'b1));
    dvs.push_back(mk_dv(80, 3, 0, 1'b1));
    dvs.push_back(mk_dv(95, 15, 0, 1'b1));
    dvs.push_back(mk_dv(96, 3, 0, 1'b0));
    dvs.push_back(mk_dv(15, 3, 0, 1'b0));
    dvs.push_back(mk_dv(496, 0, 4, 1'b1));
    dvs.push_back(mk_dv(512, 7, 7, 1'b1));
    dvs.push_back(mk_dv(528, 3, 5, 1'b1));
    dvs.push_back(mk_dv(559, 3, 0, 1'b1));
    dvs.push_back(mk_dv(560, 3, 0, 1'b0));
    dvs.push_back(mk_dv(512, 16, 0, 1'b0));
    foreach (dvs[i]) begin
      DrawX = 10'(dvs[i].x);
      DrawY = 10'(dvs[i].y);
      #1;
      check($sformatf("disp[%0d] digit", i), int'(score_bit), dvs[i].bits);
      check($sformatf("disp[%0d] area", i), int'(in_score_area), int'(dvs[i].in_area));
    end
    DrawX = 10'd0; DrawY = 10'd200;

    // Simultaneous events served ghost, power, pellet; then a dropped pellet.
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check_fields("sim newgame", 0, 4750);
    pulse(1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    check("sim drop_err before", int'(drop_err), 0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check("sim drop_err after", int'(drop_err), 1);
    ticks(5);
    check_fields("sim ghost first", 200, 4750);
    ticks(8);
    check_fields("sim power second", 250, 4750);
    ticks(8);
    check_fields("sim pellet third", 260, 4750);
    tick();
    check("sim busy done", int'(busy), 0);

    // Pump ghosts until the score saturates.
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(8);
    check_fields("sat power", 310, 4750);
    m = 310;
    ci = 0;
    for (int it = 0; it < 100 && m != 99999; it++) begin
      pulse(1'b0, 1'b0, 1'b0, 1'b1);
      ticks(8);
      m = m + gadd[ci];
      if (m > 99999) m = 99999;
      if (ci < 3) ci++;
      check_fields($sformatf("sat ghost %0d", it), m, (m > 4750) ? m : 4750);
    end
    check("sat reached", m, 99999);

    // new_game in the middle of an add.
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(3);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("abort busy", int'(busy), 0);
    check_fields("abort", 0, 99999);
    check("abort drop_err kept", int'(drop_err), 1);
    ticks(8);
    check_fields("abort settled", 0, 99999);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(8);
    check_fields("after abort pellet", 10, 99999);

    // Reset in the middle of an add.
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(2);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check_fields("midreset", 0, 0);
    check("midreset busy", int'(busy), 0);
    check("midreset drop_err", int'(drop_err), 0);
    ticks(8);
    check_fields("midreset settled", 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
